id_regfile: RTL and testbench
=============================

Name: id_regfile

Overview:
- ID-stage endpoint of the write-back interface. Consumes the WB stage's RegWriteW / wb_addr / wb_data triple.
- Holds the 32x32 MIPS general-purpose register file: one write port, two decode read ports, one debug read port.
- Same-cycle write-to-read bypass, so the decode stage sees the value being written back this cycle.
- Registers the two operands into the ID/EX pipeline register, with stall and flush control.

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of architectural registers (must equal 2**ADDR_W)

Ports:
- CLK  input  1  system clock; all state updates on posedge
- RST_N  input  1  asynchronous active-low reset
- RegWriteW  input  1  write-back enable from WB stage
- wb_addr_in  input  ADDR_W  write-back destination register
- wb_data_in  input  DATA_W  write-back data (WB selector output, stable within the cycle)
- rs_addr  input  ADDR_W  decode read port 1 address
- rt_addr  input  ADDR_W  decode read port 2 address
- StallD  input  1  hold ID/EX operand register
- FlushE  input  1  load zeros (bubble) into ID/EX operand register
- ReadData1D  output  DATA_W  combinational port-1 read, bypass applied
- ReadData2D  output  DATA_W  combinational port-2 read, bypass applied
- ReadData1E  output  DATA_W  registered port-1 operand to EX stage
- ReadData2E  output  DATA_W  registered port-2 operand to EX stage
- dbg_addr  input  ADDR_W  testbench/debug read address
- dbg_data  output  DATA_W  combinational debug read; no bypass, array contents only

Behaviour:
- Reset (RST_N low, asynchronous): all NUM_REGS entries = 0; ReadData1E = ReadData2E = 0. Reset overrides every other input.
- Write: at posedge CLK, if RegWriteW=1 and wb_addr_in != 0, then reg[wb_addr_in] <= wb_data_in. Writes to register 0 are discarded.
- Register 0 always reads 0 on all ports, including via bypass.
- Combinational read, port 1: ReadData1D =
  - 0 if rs_addr == 0;
  - else wb_data_in if RegWriteW=1 and wb_addr_in == rs_addr;
  - else reg[rs_addr].
- Port 2 is identical using rt_addr.
- Bypass latency: a write-back value is visible on ReadData*D in the same cycle it is presented, and in the array from the next cycle.
- ID/EX operand register, at posedge CLK. Priority is reset > FlushE > StallD > load.
  - FlushE=1: ReadData1E and ReadData2E <= 0. Flush wins over a simultaneous stall.
  - StallD=1, FlushE=0: hold ReadData*E.
  - Otherwise: ReadData1E <= ReadData1D, ReadData2E <= ReadData2D.
  - One-cycle latency from decode read to E outputs.
- Array writes are unaffected by StallD and FlushE. Write-back must never be lost during a stall.
- Stall held over several cycles while the source register is written: the E outputs keep their captured value. When the stall releases, the freshly bypassed or array value is loaded.
- Both read ports addressing the write target in the same cycle: both bypass.
- dbg_data = reg[dbg_addr] (0 for address 0). The bypass is deliberately excluded, so the bench can check committed state.
- Reset asserted mid-operation: the array and E outputs clear immediately. A write presented in the reset-release cycle takes effect at the first posedge with RST_N high.
- X-free: all outputs are defined from reset onward.

Decomposition:
- Shared package constants: DATA_W, ADDR_W, NUM_REGS, REG_ZERO = 0, REG_RA = 31 (jal link target).
- Natural sub-module: regfile_core, holding the array, write port, and 3 raw async read ports.
- id_regfile wraps regfile_core and adds the zero-register masking, the bypass muxes and the ID/EX register.

Test Plan:
- Reset then read: RST_N low 2 cycles, release; rs=5, rt=31 -> ReadData1D=ReadData2D=0, ReadData*E=0, dbg_data=0 for all 32 addresses.
- Write/readback: RegWriteW=1, addr=8, data=0xDEADBEEF at cycle N; cycle N+1 rs=8 -> ReadData1D=0xDEADBEEF, ReadData1E=0xDEADBEEF at N+2, dbg_addr=8 -> 0xDEADBEEF.
- Same-cycle bypass: reg9=0x11111111; present write addr=9, data=0x22222222 with rs=rt=9 -> ReadData1D=ReadData2D=0x22222222 that cycle, dbg_data(9)=0x11111111 until the posedge, then 0x22222222.
- Zero register: RegWriteW=1, addr=0, data=0xFFFFFFFF with rs=0 -> ReadData1D=0 that cycle, dbg_data(0)=0 afterwards.
- Stall/flush: load E with 0x1234 from reg4; StallD=1 for 3 cycles while reg4 is rewritten to 0x5678 -> E stays 0x1234; release -> E=0x5678; StallD=1 and FlushE=1 together -> E=0.
- Async reset mid-run: registers 1..31 filled with their index; pulse RST_N low between clock edges -> ReadData*E and all dbg_data read 0 before the next posedge.

Source files
------------

// File: rtl/id_regfile_pkg.sv
// rtl/id_regfile_pkg.sv - shared widths and register indices for the ID-stage register file
package id_regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int REG_ZERO = 0;
   localparam int REG_RA   = 31;

endpackage

// File: rtl/id_regfile_core.sv
// rtl/id_regfile_core.sv - register array with one write port and three raw async read ports
module regfile_core
   import id_regfile_pkg::*;
#(
   parameter int DATA_W   = id_regfile_pkg::DATA_W,
   parameter int ADDR_W   = id_regfile_pkg::ADDR_W,
   parameter int NUM_REGS = id_regfile_pkg::NUM_REGS
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic [ADDR_W-1:0] ra3,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic [DATA_W-1:0] rd3
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs [NUM_REGS];

   // Register 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (wr_addr != ZERO_ADDR)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd1 = regs[ra1];
   assign rd2 = regs[ra2];
   assign rd3 = regs[ra3];

endmodule

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - decode register file with write-back bypass and ID/EX operand register
module id_regfile
   import id_regfile_pkg::*;
#(
   parameter int DATA_W   = id_regfile_pkg::DATA_W,
   parameter int ADDR_W   = id_regfile_pkg::ADDR_W,
   parameter int NUM_REGS = id_regfile_pkg::NUM_REGS
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              RegWriteW,
   input  logic [ADDR_W-1:0] wb_addr_in,
   input  logic [DATA_W-1:0] wb_data_in,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic              StallD,
   input  logic              FlushE,
   output logic [DATA_W-1:0] ReadData1D,
   output logic [DATA_W-1:0] ReadData2D,
   output logic [DATA_W-1:0] ReadData1E,
   output logic [DATA_W-1:0] ReadData2E,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] raw1;
   logic [DATA_W-1:0] raw2;
   logic [DATA_W-1:0] raw_dbg;

   regfile_core #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_core (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .we      (RegWriteW),
      .wr_addr (wb_addr_in),
      .wr_data (wb_data_in),
      .ra1     (rs_addr),
      .ra2     (rt_addr),
      .ra3     (dbg_addr),
      .rd1     (raw1),
      .rd2     (raw2),
      .rd3     (raw_dbg)
   );

   // Zero check comes first so a write-back aimed at r0 never leaks through the bypass.
   always_comb begin
      ReadData1D = raw1;
      if (rs_addr == ZERO_ADDR) begin
         ReadData1D = '0;
      end else if (RegWriteW && (wb_addr_in == rs_addr)) begin
         ReadData1D = wb_data_in;
      end
   end

   always_comb begin
      ReadData2D = raw2;
      if (rt_addr == ZERO_ADDR) begin
         ReadData2D = '0;
      end else if (RegWriteW && (wb_addr_in == rt_addr)) begin
         ReadData2D = wb_data_in;
      end
   end

   assign dbg_data = (dbg_addr == ZERO_ADDR) ? '0 : raw_dbg;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ReadData1E <= '0;
         ReadData2E <= '0;
      end else if (FlushE) begin
         ReadData1E <= '0;
         ReadData2E <= '0;
      end else if (!StallD) begin
         ReadData1E <= ReadData1D;
         ReadData2E <= ReadData2D;
      end
   end

endmodule

// File: tb/tb_id_regfile.sv
// tb/tb_id_regfile.sv - directed self-checking bench for id_regfile
`timescale 1ns/100ps
module tb_id_regfile;
   import id_regfile_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        RegWriteW;
   logic [4:0]  wb_addr_in;
   logic [31:0] wb_data_in;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic        StallD;
   logic        FlushE;
   logic [31:0] ReadData1D;
   logic [31:0] ReadData2D;
   logic [31:0] ReadData1E;
   logic [31:0] ReadData2E;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   int n_cmp = 0;
   int n_bad = 0;

   id_regfile dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .RegWriteW  (RegWriteW),
      .wb_addr_in (wb_addr_in),
      .wb_data_in (wb_data_in),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .StallD     (StallD),
      .FlushE     (FlushE),
      .ReadData1D (ReadData1D),
      .ReadData2D (ReadData2D),
      .ReadData1E (ReadData1E),
      .ReadData2E (ReadData2E),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
      RegWriteW  = en;
      wb_addr_in = a;
      wb_data_in = d;
   endtask

   initial begin
      RST_N = 1'b0;
      wb(1'b0, 5'd0, 32'h0);
      rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
      StallD = 1'b0; FlushE = 1'b0;

      // reset then read
      tick(); tick();
      RST_N = 1'b1;
      rs_addr = 5'd5; rt_addr = 5'(REG_RA);
      #1;
      check_eq("rst_d1", ReadData1D, 32'h0);
      check_eq("rst_d2", ReadData2D, 32'h0);
      check_eq("rst_e1", ReadData1E, 32'h0);
      check_eq("rst_e2", ReadData2E, 32'h0);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #0.1;
         check_eq($sformatf("rst_dbg%0d", i), dbg_data, 32'h0);
      end

      // write then readback
      tick();
      wb(1'b1, 5'd8, 32'hDEADBEEF);
      tick();
      wb(1'b0, 5'd0, 32'h0);
      rs_addr = 5'd8; dbg_addr = 5'd8;
      #1;
      check_eq("wr_d1", ReadData1D, 32'hDEADBEEF);
      check_eq("wr_dbg8", dbg_data, 32'hDEADBEEF);
      tick();
      check_eq("wr_e1", ReadData1E, 32'hDEADBEEF);

      // same-cycle bypass on both ports
      wb(1'b1, 5'd9, 32'h11111111);
      tick();
      wb(1'b1, 5'd9, 32'h22222222);
      rs_addr = 5'd9; rt_addr = 5'd9; dbg_addr = 5'd9;
      #1;
      check_eq("byp_d1", ReadData1D, 32'h22222222);
      check_eq("byp_d2", ReadData2D, 32'h22222222);
      check_eq("byp_dbg_old", dbg_data, 32'h11111111);
      tick();
      wb(1'b0, 5'd0, 32'h0);
      #1;
      check_eq("byp_dbg_new", dbg_data, 32'h22222222);
      check_eq("byp_e2", ReadData2E, 32'h22222222);

      // writes to r0 are discarded, including on the bypass path
      wb(1'b1, 5'd0, 32'hFFFFFFFF);
      rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
      #1;
      check_eq("zero_d1", ReadData1D, 32'h0);
      check_eq("zero_d2", ReadData2D, 32'h0);
      tick();
      wb(1'b0, 5'd0, 32'h0);
      #1;
      check_eq("zero_dbg", dbg_data, 32'h0);
      check_eq("zero_e1", ReadData1E, 32'h0);

      // stall holds E while write-back continues, flush beats stall
      wb(1'b1, 5'd4, 32'h00001234);
      tick();
      wb(1'b0, 5'd0, 32'h0);
      rs_addr = 5'd4; rt_addr = 5'd8; dbg_addr = 5'd4;
      tick();
      check_eq("stl_load_e1", ReadData1E, 32'h00001234);
      check_eq("stl_load_e2", ReadData2E, 32'hDEADBEEF);
      StallD = 1'b1;
      wb(1'b1, 5'd4, 32'h00005678);
      tick();
      wb(1'b0, 5'd0, 32'h0);
      check_eq("stl_hold1", ReadData1E, 32'h00001234);
      check_eq("stl_dbg4", dbg_data, 32'h00005678);
      tick();
      check_eq("stl_hold2", ReadData1E, 32'h00001234);
      tick();
      check_eq("stl_hold3", ReadData1E, 32'h00001234);
      StallD = 1'b0;
      tick();
      check_eq("stl_release", ReadData1E, 32'h00005678);
      StallD = 1'b1; FlushE = 1'b1;
      tick();
      check_eq("flush_e1", ReadData1E, 32'h0);
      check_eq("flush_e2", ReadData2E, 32'h0);
      StallD = 1'b0; FlushE = 1'b0;

      // fill r1..r31 with their index, then reset mid-cycle
      for (int i = 1; i < 32; i++) begin
         wb(1'b1, 5'(i), 32'(i));
         tick();
      end
      wb(1'b0, 5'd0, 32'h0);
      rs_addr = 5'd3; rt_addr = 5'(REG_RA); dbg_addr = 5'd17;
      tick();
      check_eq("fill_e1", ReadData1E, 32'd3);
      check_eq("fill_e2", ReadData2E, 32'd31);
      check_eq("fill_dbg17", dbg_data, 32'd17);
      RST_N = 1'b0;
      #0.1;
      check_eq("arst_e1", ReadData1E, 32'h0);
      check_eq("arst_e2", ReadData2E, 32'h0);
      check_eq("arst_d1", ReadData1D, 32'h0);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #0.1;
         check_eq($sformatf("arst_dbg%0d", i), dbg_data, 32'h0);
      end

      // write presented in the reset-release cycle lands at the first live edge
      wb(1'b1, 5'd7, 32'h0000A5A5);
      dbg_addr = 5'd7;
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      check_eq("rel_pre", dbg_data, 32'h0);
      tick();
      wb(1'b0, 5'd0, 32'h0);
      #1;
      check_eq("rel_post", dbg_data, 32'h0000A5A5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
